accumulator_sequencer: RTL and testbench

Parametrised instruction-cycle controller for the accumulator machine. It owns PC, IR, ACC and the memory address/data registers, and runs a fetch/decode/execute state machine against a single variable-latency memory port with a req/ready handshake. It replaces the fixed 16-bit step counter and the free-standing registers in the top-level computer, and sits between the clock/reset source and main memory.

---
 rtl/cpu_pkg.sv | 61 ++++++
 rtl/alu_n.sv | 30 +++
 rtl/accumulator_sequencer.sv | 148 ++++++++++++++
 tb/tb_accumulator_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator machine: opcodes, sequencer states
// and the mapping from an instruction opcode to the ALU operation it needs.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP     = 4'h0,
    OP_LOAD    = 4'h1,
    OP_STORE   = 4'h2,
    OP_ADD     = 4'h3,
    OP_SUB     = 4'h4,
    OP_AND     = 4'h5,
    OP_OR      = 4'h6,
    OP_XOR     = 4'h7,
    OP_SHL     = 4'h8,
    OP_SHR     = 4'h9,
    OP_JMP     = 4'hA,
    OP_JZ      = 4'hB,
    OP_LDI     = 4'hC,
    OP_JN      = 4'hD,
    OP_ILLEGAL = 4'hE,
    OP_HALT    = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_MEMOP  = 2'd2,
    S_HALT   = 2'd3
  } state_e;

  // Operation encoding inherited from the previous ALU; the operand order is
  // always a = ACC, b = memory data.
  typedef enum logic [3:0] {
    ALU_PASS_A = 4'h0,
    ALU_PASS_B = 4'h1,
    ALU_ADD    = 4'h2,
    ALU_SUB    = 4'h3,
    ALU_AND    = 4'h4,
    ALU_OR     = 4'h5,
    ALU_XOR    = 4'h6,
    ALU_SHL    = 4'h7,
    ALU_SHR    = 4'h8
  } alu_op_e;

  function automatic alu_op_e alu_op_for(input opcode_e opcode);
    alu_op_e op;
    case (opcode)
      OP_LOAD:  op = ALU_PASS_B;
      OP_ADD:   op = ALU_ADD;
      OP_SUB:   op = ALU_SUB;
      OP_AND:   op = ALU_AND;
      OP_OR:    op = ALU_OR;
      OP_XOR:   op = ALU_XOR;
      OP_SHL:   op = ALU_SHL;
      OP_SHR:   op = ALU_SHR;
      default:  op = ALU_PASS_A;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_n.sv
// Combinational DATA_WIDTH-wide ALU; arithmetic wraps modulo 2^DATA_WIDTH
// and single-bit shifts fill with zero.
module alu_n
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  alu_op_e               op,
  output logic [DATA_WIDTH-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      ALU_PASS_A: y = a;
      ALU_PASS_B: y = b;
      ALU_ADD:    y = a + b;
      ALU_SUB:    y = a - b;
      ALU_AND:    y = a & b;
      ALU_OR:     y = a | b;
      ALU_XOR:    y = a ^ b;
      ALU_SHL:    y = a << 1;
      ALU_SHR:    y = a >> 1;
      default:    y = a;
    endcase
  end

endmodule

// File: rtl/accumulator_sequencer.sv
// Fetch/decode/execute controller for the accumulator machine; owns PC, IR,
// ACC and MAR and talks to one variable-latency memory port via req/ready.
module accumulator_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int OPCODE_WIDTH = 4,
  parameter int ADDR_WIDTH   = DATA_WIDTH - OPCODE_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] acc,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted,
  output logic                  illegal
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [ADDR_WIDTH-1:0] mar_q, mar_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  halted_q, halted_d;
  logic                  illegal_q, illegal_d;

  opcode_e               opcode;
  logic [ADDR_WIDTH-1:0] operand;
  alu_op_e               alu_op;
  logic [DATA_WIDTH-1:0] alu_y;

  assign opcode  = opcode_e'(ir_q[DATA_WIDTH-1 -: OPCODE_WIDTH]);
  assign operand = ir_q[ADDR_WIDTH-1:0];
  assign alu_op  = alu_op_for(opcode);

  // Shifts in DECODE and every ACC-op-memory result in MEMOP share this ALU;
  // shifts simply ignore the b operand.
  alu_n #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .a  (acc_q),
    .b  (mem_rdata),
    .op (alu_op),
    .y  (alu_y)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      mar_q     <= '0;
      acc_q     <= '0;
      pc_q      <= RESET_PC;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      mar_q     <= mar_d;
      acc_q     <= acc_d;
      pc_q      <= pc_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  // Request address, direction and data derive only from registers that are
  // frozen while a request waits, so they stay stable until ready arrives.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    mar_d     = mar_q;
    acc_d     = acc_q;
    pc_d      = pc_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;

    case (state_q)
      S_FETCH: begin
        if (run) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_d    = mem_rdata;
            pc_d    = pc_q + 1'b1;
            state_d = S_DECODE;
          end
        end
      end

      S_DECODE: begin
        state_d = S_FETCH;
        case (opcode)
          OP_NOP: ;
          OP_SHL, OP_SHR: acc_d = alu_y;
          OP_LDI: acc_d = {{OPCODE_WIDTH{1'b0}}, operand};
          OP_JMP: pc_d = operand;
          OP_JZ:  if (acc_q == '0) pc_d = operand;
          OP_JN:  if (acc_q[DATA_WIDTH-1]) pc_d = operand;
          OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            mar_d   = operand;
            state_d = S_MEMOP;
          end
          OP_ILLEGAL: begin
            illegal_d = 1'b1;
            halted_d  = 1'b1;
            state_d   = S_HALT;
          end
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEMOP: begin
        mem_req  = 1'b1;
        mem_addr = mar_q;
        mem_we   = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode != OP_STORE) acc_d = alu_y;
          state_d = S_FETCH;
        end
      end

      S_HALT: ;

      default: state_d = S_FETCH;
    endcase
  end

  assign mem_wdata = acc_q;
  assign acc       = acc_q;
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Self-checking bench: variable-latency memory model plus an instruction-level
// reference interpreter; RESET_PC=0xFFF so every program first wraps through NOP.
module tb_accumulator_sequencer;

  localparam logic [11:0] RST_PC = 12'hFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        mem_req, mem_we, mem_ready;
  logic [11:0] mem_addr, pc;
  logic [15:0] mem_wdata, mem_rdata, acc;
  logic        halted, illegal;

  logic [15:0] mem     [0:4095];
  logic [15:0] img     [0:4095];
  logic [15:0] ref_mem [0:4095];

  int          wait_cnt = 0;
  int          latency = 0;
  int          fixed_lat = 0;
  bit          rand_lat = 1'b0;
  int          max_lat = 3;
  bit          clr_req = 1'b0;
  bit          ld_req = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [15:0] ld_data = '0;

  int total = 0;
  int bad = 0;

  accumulator_sequencer #(
    .DATA_WIDTH(16), .OPCODE_WIDTH(4), .ADDR_WIDTH(12), .RESET_PC(RST_PC)
  ) dut (
    .clock(clock), .reset(reset), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .acc(acc), .pc(pc), .halted(halted), .illegal(illegal)
  );

  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = mem_req && (wait_cnt == latency);

  function automatic int pick_lat();
    return rand_lat ? int'($urandom_range(0, max_lat)) : fixed_lat;
  endfunction

  // Memory: ready after 'latency' wait cycles; abandoned requests are dropped.
  always @(posedge clock) begin
    if (clr_req) begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;
    end else if (ld_req) begin
      mem[ld_addr] = ld_data;
    end
    if (reset) begin
      wait_cnt <= 0;
      latency  <= pick_lat();
    end else if (mem_req && mem_ready) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      wait_cnt <= 0;
      latency  <= pick_lat();
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
    end
  end

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    ld_addr = a;
    ld_data = d;
    ld_req  = 1'b1;
    img[a]  = d;
    @(posedge clock);
    @(negedge clock);
    ld_req = 1'b0;
  endtask

  task automatic begin_test(input int lat, input bit rnd);
    @(negedge clock);
    reset     = 1'b1;
    run       = 1'b0;
    fixed_lat = lat;
    rand_lat  = rnd;
    for (int i = 0; i < 4096; i++) img[i] = '0;
    clr_req = 1'b1;
    @(posedge clock);
    @(negedge clock);
    clr_req = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Instruction-level interpreter; cycle cost is 2 per instruction plus one
  // more for a data access, plus 'lat' per memory request.
  task automatic model_run(input int lat, output logic [15:0] m_acc, output logic [11:0] m_pc,
                           output bit m_halt, output bit m_ill, output int m_cycles);
    logic [15:0] a_m, word, val;
    logic [11:0] p_m, a;
    int          op;
    for (int i = 0; i < 4096; i++) ref_mem[i] = img[i];
    a_m = '0; p_m = RST_PC; m_halt = 1'b0; m_ill = 1'b0; m_cycles = 0;
    for (int n = 0; n < 2000 && !m_halt; n++) begin
      word = ref_mem[p_m];
      p_m  = p_m + 12'd1;
      op   = int'(word[15:12]);
      a    = word[11:0];
      val  = ref_mem[a];
      if (op >= 1 && op <= 7) m_cycles += 3 + 2 * lat;
      else m_cycles += 2 + lat;
      case (op)
        1:  a_m = val;
        2:  ref_mem[a] = a_m;
        3:  a_m = a_m + val;
        4:  a_m = a_m - val;
        5:  a_m = a_m & val;
        6:  a_m = a_m | val;
        7:  a_m = a_m ^ val;
        8:  a_m = a_m * 16'd2;
        9:  a_m = a_m / 16'd2;
        10: p_m = a;
        11: if (a_m == 16'd0) p_m = a;
        12: a_m = 16'(a);
        13: if (a_m >= 16'h8000) p_m = a;
        14: begin m_ill = 1'b1; m_halt = 1'b1; end
        15: m_halt = 1'b1;
        default: ;
      endcase
    end
    m_acc = a_m;
    m_pc  = p_m;
  endtask

  task automatic run_program(input int budget, output int cycles, output int stab_bad, output bit timed_out);
    bit          pend;
    logic [11:0] p_addr;
    logic        p_we;
    logic [15:0] p_wdata;
    cycles = 0; stab_bad = 0; timed_out = 1'b0;
    run = 1'b1;
    #1;
    pend = mem_req && !mem_ready; p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
    forever begin
      @(posedge clock);
      cycles++;
      @(negedge clock);
      if (pend && (!mem_req || mem_addr !== p_addr || mem_we !== p_we || (p_we && mem_wdata !== p_wdata)))
        stab_bad++;
      pend = mem_req && !mem_ready; p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
      if (halted) break;
      if (cycles >= budget) begin timed_out = 1'b1; break; end
    end
    run = 1'b0;
  endtask

  task automatic test_reset();
    int req_seen = 0;
    begin_test(0, 1'b0);
    release_reset();
    total++; if (acc !== 16'h0) begin bad++; $display("[TB] FAIL reset_acc: got %h want 0000", acc); end
    total++; if (pc !== RST_PC) begin bad++; $display("[TB] FAIL reset_pc: got %h want %h", pc, RST_PC); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL reset_req: got %b want 0", mem_req); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_we: got %b want 0", mem_we); end
    total++; if (mem_wdata !== 16'h0) begin bad++; $display("[TB] FAIL reset_wdata: got %h want 0000", mem_wdata); end
    total++; if (halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_halted: got %b want 0", halted); end
    total++; if (illegal !== 1'b0) begin bad++; $display("[TB] FAIL reset_illegal: got %b want 0", illegal); end
    repeat (5) begin
      @(posedge clock);
      @(negedge clock);
      if (mem_req !== 1'b0) req_seen++;
    end
    total++; if (req_seen !== 0) begin bad++; $display("[TB] FAIL idle_no_req: got %0d requests want 0", req_seen); end
    total++; if (pc !== RST_PC) begin bad++; $display("[TB] FAIL idle_pc: got %h want %h", pc, RST_PC); end
  endtask

  task automatic test_spec_program(input int lat, input string tag);
    logic [15:0] m_acc;
    logic [11:0] m_pc;
    bit          m_halt, m_ill, to;
    int          m_cyc, cyc, stab;
    begin_test(lat, 1'b0);
    poke(12'h000, 16'hC005);
    poke(12'h001, 16'h3010);
    poke(12'h002, 16'h2011);
    poke(12'h003, 16'hF000);
    poke(12'h010, 16'h0007);
    release_reset();
    model_run(lat, m_acc, m_pc, m_halt, m_ill, m_cyc);
    run_program(500, cyc, stab, to);
    total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL %s_timeout: no halt within budget", tag); end
    total++; if (cyc !== m_cyc) begin bad++; $display("[TB] FAIL %s_cycles: got %0d want %0d", tag, cyc, m_cyc); end
    total++; if (mem[12'h011] !== 16'd12) begin bad++; $display("[TB] FAIL %s_store: got %h want 000c", tag, mem[12'h011]); end
    total++; if (mem[12'h011] !== ref_mem[12'h011]) begin bad++; $display("[TB] FAIL %s_store_model: got %h want %h", tag, mem[12'h011], ref_mem[12'h011]); end
    total++; if (acc !== m_acc) begin bad++; $display("[TB] FAIL %s_acc: got %h want %h", tag, acc, m_acc); end
    total++; if (pc !== m_pc) begin bad++; $display("[TB] FAIL %s_pc: got %h want %h", tag, pc, m_pc); end
    total++; if (halted !== 1'b1) begin bad++; $display("[TB] FAIL %s_halted: got %b want 1", tag, halted); end
    total++; if (illegal !== 1'b0) begin bad++; $display("[TB] FAIL %s_illegal: got %b want 0", tag, illegal); end
    total++; if (stab !== 0) begin bad++; $display("[TB] FAIL %s_stable: got %0d unstable waits want 0", tag, stab); end
  endtask

  task automatic test_branches();
    logic [15:0] m_acc;
    logic [11:0] m_pc;
    bit          m_halt, m_ill, to;
    int          m_cyc, cyc, stab;
    max_lat = 2;
    begin_test(0, 1'b1);
    poke(12'h000, 16'hC000);
    poke(12'h001, 16'hB020);
    poke(12'h020, 16'hC001);
    poke(12'h021, 16'hD000);
    poke(12'h022, 16'hF000);
    release_reset();
    model_run(0, m_acc, m_pc, m_halt, m_ill, m_cyc);
    run_program(500, cyc, stab, to);
    total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL branch_timeout: no halt within budget"); end
    total++; if (acc !== 16'h0001) begin bad++; $display("[TB] FAIL branch_acc: got %h want 0001", acc); end
    total++; if (pc !== 12'h023) begin bad++; $display("[TB] FAIL branch_pc: got %h want 023", pc); end
    total++; if (pc !== m_pc) begin bad++; $display("[TB] FAIL branch_pc_model: got %h want %h", pc, m_pc); end
    total++; if (stab !== 0) begin bad++; $display("[TB] FAIL branch_stable: got %0d want 0", stab); end
  endtask

  task automatic test_illegal();
    logic [15:0] m_acc;
    logic [11:0] m_pc;
    bit          m_halt, m_ill, to;
    int          m_cyc, cyc, stab;
    int          req_seen = 0;
    begin_test(1, 1'b0);
    poke(12'h000, 16'hC003);
    poke(12'h001, 16'hE000);
    poke(12'h002, 16'hF000);
    release_reset();
    model_run(1, m_acc, m_pc, m_halt, m_ill, m_cyc);
    run_program(500, cyc, stab, to);
    total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL illegal_timeout: no halt within budget"); end
    total++; if (illegal !== m_ill) begin bad++; $display("[TB] FAIL illegal_flag: got %b want %b", illegal, m_ill); end
    total++; if (halted !== 1'b1) begin bad++; $display("[TB] FAIL illegal_halted: got %b want 1", halted); end
    total++; if (acc !== m_acc) begin bad++; $display("[TB] FAIL illegal_acc: got %h want %h", acc, m_acc); end
    total++; if (cyc !== m_cyc) begin bad++; $display("[TB] FAIL illegal_cycles: got %0d want %0d", cyc, m_cyc); end
    run = 1'b1;
    repeat (20) begin
      @(posedge clock);
      @(negedge clock);
      if (mem_req !== 1'b0) req_seen++;
    end
    run = 1'b0;
    total++; if (req_seen !== 0) begin bad++; $display("[TB] FAIL illegal_no_req: got %0d requests want 0", req_seen); end
    total++; if (pc !== m_pc) begin bad++; $display("[TB] FAIL illegal_pc: got %h want %h", pc, m_pc); end
  endtask

  task automatic test_reset_during_store();
    bit found = 1'b0;
    int req_seen = 0;
    begin_test(5, 1'b0);
    poke(12'h000, 16'hC009);
    poke(12'h001, 16'h2050);
    poke(12'h002, 16'hF000);
    poke(12'h050, 16'h1234);
    release_reset();
    run = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (mem_req && mem_we) begin found = 1'b1; break; end
    end
    total++; if (found !== 1'b1) begin bad++; $display("[TB] FAIL rst_store_seen: store request not observed"); end
    total++; if (mem_wdata !== 16'h0009) begin bad++; $display("[TB] FAIL rst_store_wdata: got %h want 0009", mem_wdata); end
    total++; if (mem_addr !== 12'h050) begin bad++; $display("[TB] FAIL rst_store_addr: got %h want 050", mem_addr); end
    reset = 1'b1;
    run   = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    total++; if (mem_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_store_req: got %b want 0", mem_req); end
    total++; if (acc !== 16'h0) begin bad++; $display("[TB] FAIL rst_store_acc: got %h want 0000", acc); end
    total++; if (pc !== RST_PC) begin bad++; $display("[TB] FAIL rst_store_pc: got %h want %h", pc, RST_PC); end
    total++; if (mem_wdata !== 16'h0 || mem_we !== 1'b0) begin bad++; $display("[TB] FAIL rst_store_wr: got we=%b wdata=%h want 0/0000", mem_we, mem_wdata); end
    total++; if (halted !== 1'b0 || illegal !== 1'b0) begin bad++; $display("[TB] FAIL rst_store_flags: got %b%b want 00", halted, illegal); end
    repeat (10) begin
      @(posedge clock);
      @(negedge clock);
      if (mem_req !== 1'b0) req_seen++;
    end
    total++; if (req_seen !== 0) begin bad++; $display("[TB] FAIL rst_store_idle: got %0d requests want 0", req_seen); end
    total++; if (mem[12'h050] !== 16'h1234) begin bad++; $display("[TB] FAIL rst_store_nowrite: got %h want 1234", mem[12'h050]); end
  endtask

  task automatic test_random_programs();
    logic [15:0] m_acc;
    logic [11:0] m_pc, opnd;
    logic [3:0]  op;
    bit          m_halt, m_ill, to;
    int          m_cyc, cyc, stab, diff;
    max_lat = 3;
    for (int it = 0; it < 6; it++) begin
      begin_test(0, bit'(it % 2));
      for (int i = 0; i < 20; i++) begin
        op = 4'($urandom_range(0, 13));
        if (op >= 4'h1 && op <= 4'h7) opnd = 12'h100 + 12'($urandom_range(0, 15));
        else if (op == 4'hA || op == 4'hB || op == 4'hD) opnd = 12'($urandom_range(i + 1, 20));
        else opnd = 12'($urandom_range(0, 4095));
        poke(12'(i), {op, opnd});
      end
      poke(12'd20, 16'hF000);
      for (int i = 0; i < 16; i++) poke(12'h100 + 12'(i), 16'($urandom));
      release_reset();
      model_run(0, m_acc, m_pc, m_halt, m_ill, m_cyc);
      run_program(1000, cyc, stab, to);
      diff = 0;
      for (int i = 0; i < 16; i++) if (mem[12'h100 + i] !== ref_mem[12'h100 + i]) diff++;
      total++; if (to !== 1'b0) begin bad++; $display("[TB] FAIL rand%0d_timeout: no halt within budget", it); end
      total++; if (acc !== m_acc) begin bad++; $display("[TB] FAIL rand%0d_acc: got %h want %h", it, acc, m_acc); end
      total++; if (pc !== m_pc) begin bad++; $display("[TB] FAIL rand%0d_pc: got %h want %h", it, pc, m_pc); end
      total++; if (halted !== 1'b1 || illegal !== 1'b0) begin bad++; $display("[TB] FAIL rand%0d_flags: got %b%b want 10", it, halted, illegal); end
      total++; if (diff !== 0) begin bad++; $display("[TB] FAIL rand%0d_data: got %0d differing words want 0", it, diff); end
      total++; if (stab !== 0) begin bad++; $display("[TB] FAIL rand%0d_stable: got %0d want 0", it, stab); end
      if (it % 2 == 0) begin
        total++; if (cyc !== m_cyc) begin bad++; $display("[TB] FAIL rand%0d_cycles: got %0d want %0d", it, cyc, m_cyc); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_spec_program(0, "zero_wait");
    test_spec_program(3, "wait3");
    test_branches();
    test_illegal();
    test_reset_during_store();
    test_random_programs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
